// File: rtl/wiper_sweep.sv
// Wiper arm sweep sequencer: walks an arm position 0..POS_MAX and back
// at a mode-dependent step rate, always returning to park before stopping,
// and counts completed sweeps.
//
// Handshake: there is none; mode is a level sampled on every rising edge.
// dbg_state exposes the FSM state (0 PARK, 1 UP, 2 DOWN).
module wiper_sweep #(
  parameter int SLOW_DIV = 8,
  parameter int FAST_DIV = 4,
  parameter int POS_MAX  = 6
) (
  input  logic       clk_2,
  input  logic       reset_n,
  input  logic [1:0] mode,
  output logic [2:0] pos,
  output logic [6:0] led_bar,
  output logic       parked,
  output logic       busy,
  output logic       speed,
  output logic [7:0] sweep_cnt,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    ST_PARK = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  localparam logic [15:0] LP_SLOW    = 16'(SLOW_DIV);
  localparam logic [15:0] LP_FAST    = 16'(FAST_DIV);
  localparam logic [2:0]  LP_POS_MAX = 3'(POS_MAX);

  state_t      r_state;
  logic [2:0]  r_pos;
  logic [6:0]  r_led_bar;
  logic        r_parked;
  logic        r_busy;
  logic        r_speed;
  logic [15:0] r_div;
  logic [7:0]  r_sweep_cnt;
  // Set when an off request reverses the arm mid-rise; that return to 0
  // is not a completed sweep and must not be counted.
  logic        r_abort;

  logic        w_active;
  logic [15:0] w_cur_div;
  logic        w_step;
  state_t      w_nxt_state;
  logic [2:0]  w_nxt_pos;
  logic [15:0] w_nxt_div;
  logic        w_nxt_abort;
  logic        w_inc_cnt;

  // Next-state, position and divider decision for the current cycle.
  always_comb begin
    w_active    = (mode == 2'd1) || (mode == 2'd2);
    w_cur_div   = r_speed ? LP_FAST : LP_SLOW;
    // >= rather than == so a slow->fast switch with div already past the
    // fast limit steps immediately instead of wrapping the counter.
    w_step      = (r_div >= (w_cur_div - 16'd1));
    w_nxt_state = r_state;
    w_nxt_pos   = r_pos;
    w_nxt_div   = r_div;
    w_nxt_abort = r_abort;
    w_inc_cnt   = 1'b0;
    case (r_state)
      ST_PARK: begin
        w_nxt_div   = 16'd0;
        w_nxt_abort = 1'b0;
        if (w_active) w_nxt_state = ST_UP;
      end
      ST_UP: begin
        if (w_step) begin
          w_nxt_div = 16'd0;
          if (!w_active) begin
            // Reversal; an arm at 0 or 1 lands on park right away.
            if (r_pos <= 3'd1) begin
              w_nxt_pos   = 3'd0;
              w_nxt_state = ST_PARK;
              w_nxt_abort = 1'b0;
            end else begin
              w_nxt_pos   = r_pos - 3'd1;
              w_nxt_state = ST_DOWN;
              w_nxt_abort = 1'b1;
            end
          end else begin
            w_nxt_pos = r_pos + 3'd1;
            if ((r_pos + 3'd1) == LP_POS_MAX) w_nxt_state = ST_DOWN;
          end
        end else begin
          w_nxt_div = r_div + 16'd1;
        end
      end
      ST_DOWN: begin
        if (w_step) begin
          w_nxt_div = 16'd0;
          w_nxt_pos = r_pos - 3'd1;
          if (r_pos == 3'd1) begin
            w_inc_cnt   = !r_abort;
            w_nxt_abort = 1'b0;
            w_nxt_state = w_active ? ST_UP : ST_PARK;
          end
        end else begin
          w_nxt_div = r_div + 16'd1;
        end
      end
      default: begin
        w_nxt_state = ST_PARK;
        w_nxt_pos   = 3'd0;
        w_nxt_div   = 16'd0;
        w_nxt_abort = 1'b0;
      end
    endcase
  end

  // State register with all outputs registered from the next-state values.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_PARK;
      r_pos       <= 3'd0;
      r_led_bar   <= 7'b0000001;
      r_parked    <= 1'b1;
      r_busy      <= 1'b0;
      r_speed     <= 1'b0;
      r_div       <= 16'd0;
      r_sweep_cnt <= 8'd0;
      r_abort     <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_pos     <= w_nxt_pos;
      r_led_bar <= 7'b0000001 << w_nxt_pos;
      r_parked  <= (w_nxt_state == ST_PARK);
      r_busy    <= (w_nxt_state != ST_PARK);
      if (w_active) r_speed <= (mode == 2'd2);
      r_div     <= w_nxt_div;
      if (w_inc_cnt) r_sweep_cnt <= r_sweep_cnt + 8'd1;
      r_abort   <= w_nxt_abort;
    end
  end

  assign pos       = r_pos;
  assign led_bar   = r_led_bar;
  assign parked    = r_parked;
  assign busy      = r_busy;
  assign speed     = r_speed;
  assign sweep_cnt = r_sweep_cnt;
  assign dbg_state = r_state;

endmodule
